mem_stage: RTL and testbench

//  Pipeline stage directly downstream of EX. Registers the EX->MEM bus and aligns/extends
//  the synchronous data-SRAM read word for loads. Resolves the final GPR write value
//  (load data, mfhi/mflo data or ALU result) and drives MEM->WB and MEM->ID (forwarding).

---
 rtl/mem_stage_pkg.sv | 75 +++++++
 rtl/mem_stage_load_align.sv | 41 ++++
 rtl/mem_stage.sv | 102 ++++++++++
 tb/tb_mem_stage.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage: bus layouts,
// stall encoding, one-hot load-op bit positions and extension helpers.
package mem_stage_pkg;

  // Pipeline stall vector: one bit per stage, MEM at [3], WB at [4].
  localparam int STALL_BUS = 6;
  localparam int STALL_MEM = 3;
  localparam int STALL_WB  = 4;
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // One-hot load-op bit indices within ld_op[4:0] = {lw,lhu,lh,lbu,lb}.
  localparam int LD_LB  = 0;
  localparam int LD_LBU = 1;
  localparam int LD_LH  = 2;
  localparam int LD_LHU = 3;
  localparam int LD_LW  = 4;
  localparam int LD_OP_WD = 5;

  // EX -> MEM bus; ld_op occupies the MSBs.
  typedef struct packed {
    logic [LD_OP_WD-1:0] ld_op;
    logic                r_hi;
    logic [31:0]         r_hi_data;
    logic                r_lo;
    logic [31:0]         r_lo_data;
    logic                hi_we;
    logic [31:0]         hi_wdata;
    logic                lo_we;
    logic [31:0]         lo_wdata;
    logic [31:0]         pc;
    logic                sel_rf_res;
    logic                rf_we;
    logic [4:0]          rf_waddr;
    logic [31:0]         ex_result;
  } ex_to_mem_t;

  // MEM -> WB bus.
  typedef struct packed {
    logic        hi_we;
    logic [31:0] hi_wdata;
    logic        lo_we;
    logic [31:0] lo_wdata;
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } mem_to_wb_t;

  // MEM -> ID forwarding bus (same as WB bus without pc).
  typedef struct packed {
    logic        hi_we;
    logic [31:0] hi_wdata;
    logic        lo_we;
    logic [31:0] lo_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } mem_to_id_t;

  localparam int EX_TO_MEM_WD = $bits(ex_to_mem_t);
  localparam int MEM_TO_WB_WD = $bits(mem_to_wb_t);
  localparam int MEM_TO_ID_WD = $bits(mem_to_id_t);

  // Extend a byte to 32 bits, sign-extending when sgn is set.
  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  // Extend a halfword to 32 bits, sign-extending when sgn is set.
  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks the addressed byte/halfword/word out of the
// SRAM read word and sign- or zero-extends it. Misaligned addresses are
// not trapped; the low address bits a width does not use are ignored.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [LD_OP_WD-1:0] ld_op,
  input  logic [1:0]          addr,
  input  logic [31:0]         rdata,
  output logic [31:0]         data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed byte and halfword lanes.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and a latch can never be inferred.
    byte_sel = rdata[7:0];
    case (addr)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  // Apply the width and extension chosen by the one-hot load op.
  always_comb begin
    data = '0;
    if (ld_op[LD_LW])       data = rdata;
    else if (ld_op[LD_LHU]) data = ext16(half_sel, 1'b0);
    else if (ld_op[LD_LH])  data = ext16(half_sel, 1'b1);
    else if (ld_op[LD_LBU]) data = ext8(byte_sel, 1'b0);
    else if (ld_op[LD_LB])  data = ext8(byte_sel, 1'b1);
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EX result bus, holds the synchronous
// SRAM read word across MEM freezes, aligns load data and resolves the
// final GPR write value for WB and for forwarding into ID.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_BUS-1:0]    stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus
);

  ex_to_mem_t  bus_r;
  logic        first_r;
  logic [31:0] rdata_hold_r;
  logic [31:0] rdata_eff;
  logic [31:0] load_data;
  logic [31:0] rf_wdata;
  logic        mem_stop;
  logic        wb_stop;
  logic        bubble;
  logic        advance;
  mem_to_wb_t  wb;
  mem_to_id_t  id;

  // Stall bits owned by other stages are not consumed here.
  logic unused_stall;
  assign unused_stall = ^{stall[STALL_BUS-1:STALL_WB+1], stall[STALL_MEM-1:0]};

  assign mem_stop = (stall[STALL_MEM] == STOP);
  assign wb_stop  = (stall[STALL_WB]  == STOP);
  assign bubble   = mem_stop && !wb_stop;
  assign advance  = !mem_stop;

  // EX->MEM register: reset, insert a bubble, load a new bus, or hold.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    if (rst)          bus_r <= '0;
    else if (bubble)  bus_r <= '0;
    else if (advance) bus_r <= ex_to_mem_bus;
  end

  // first_r marks the single cycle in which the SRAM word belongs to the
  // instruction now in MEM; afterwards the held copy is authoritative.
  always_ff @(posedge clk) begin
    if (rst) first_r <= 1'b0;
    else     first_r <= advance;
  end

  // Capture the SRAM word during the first MEM cycle so a freeze keeps it.
  always_ff @(posedge clk) begin
    if (rst)          rdata_hold_r <= '0;
    else if (first_r) rdata_hold_r <= data_sram_rdata;
  end

  assign rdata_eff = first_r ? data_sram_rdata : rdata_hold_r;

  load_align u_load_align (
    .ld_op (bus_r.ld_op),
    .addr  (bus_r.ex_result[1:0]),
    .rdata (rdata_eff),
    .data  (load_data)
  );

  // Final GPR write value: mfhi, then mflo, then load data, else ALU result.
  always_comb begin
    rf_wdata = bus_r.ex_result;
    if (bus_r.r_hi)                           rf_wdata = bus_r.r_hi_data;
    else if (bus_r.r_lo)                      rf_wdata = bus_r.r_lo_data;
    else if (bus_r.sel_rf_res && |bus_r.ld_op) rf_wdata = load_data;
  end

  // Assemble the WB and ID buses from the registered fields.
  always_comb begin
    wb          = '0;
    wb.hi_we    = bus_r.hi_we;
    wb.hi_wdata = bus_r.hi_wdata;
    wb.lo_we    = bus_r.lo_we;
    wb.lo_wdata = bus_r.lo_wdata;
    wb.pc       = bus_r.pc;
    wb.rf_we    = bus_r.rf_we;
    wb.rf_waddr = bus_r.rf_waddr;
    wb.rf_wdata = rf_wdata;

    id          = '0;
    id.hi_we    = bus_r.hi_we;
    id.hi_wdata = bus_r.hi_wdata;
    id.lo_we    = bus_r.lo_we;
    id.lo_wdata = bus_r.lo_wdata;
    id.rf_we    = bus_r.rf_we;
    id.rf_waddr = bus_r.rf_waddr;
    id.rf_wdata = rf_wdata;
  end

  assign mem_to_wb_bus = wb;
  assign mem_to_id_bus = id;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a table of load-alignment vectors
// plus hand-written sequences for stalls, bubbles, hi/lo reads and reset.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [STALL_BUS-1:0]    stall;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic [31:0]             data_sram_rdata;
  logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
  logic [MEM_TO_ID_WD-1:0] mem_to_id_bus;

  mem_to_wb_t wb;
  mem_to_id_t id;
  assign wb = mem_to_wb_bus;
  assign id = mem_to_id_bus;

  mem_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .data_sram_rdata (data_sram_rdata),
    .mem_to_wb_bus   (mem_to_wb_bus),
    .mem_to_id_bus   (mem_to_id_bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic ex_to_mem_t make_bus(input logic [4:0] ld_op, input logic [31:0] ex_result,
                                          input logic sel, input logic [4:0] waddr);
    ex_to_mem_t b;
    b            = '0;
    b.ld_op      = ld_op;
    b.ex_result  = ex_result;
    b.sel_rf_res = sel;
    b.rf_we      = 1'b1;
    b.rf_waddr   = waddr;
    b.pc         = 32'hBFC0_0100;
    return b;
  endfunction

  typedef struct {
    logic [4:0]  ld_op;
    logic [31:0] ex_result;
    logic        sel;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;

  localparam logic [4:0] OP_LB  = 5'b00001;
  localparam logic [4:0] OP_LBU = 5'b00010;
  localparam logic [4:0] OP_LH  = 5'b00100;
  localparam logic [4:0] OP_LHU = 5'b01000;
  localparam logic [4:0] OP_LW  = 5'b10000;

  vec_t vecs[12];

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ex_to_mem_t b;

    vecs[0]  = '{OP_LB,  32'h1000_0001, 1'b1, 32'h1234_80FF, 32'hFFFF_FF80};
    vecs[1]  = '{OP_LHU, 32'h1000_0002, 1'b1, 32'h9ABC_0000, 32'h0000_9ABC};
    vecs[2]  = '{OP_LH,  32'h1000_0002, 1'b1, 32'h9ABC_0000, 32'hFFFF_9ABC};
    vecs[3]  = '{OP_LBU, 32'h1000_0001, 1'b1, 32'h1234_80FF, 32'h0000_0080};
    vecs[4]  = '{OP_LB,  32'h1000_0000, 1'b1, 32'h1234_80FF, 32'hFFFF_FFFF};
    vecs[5]  = '{OP_LB,  32'h1000_0003, 1'b1, 32'h1234_80FF, 32'h0000_0012};
    vecs[6]  = '{OP_LH,  32'h1000_0003, 1'b1, 32'h9ABC_0000, 32'hFFFF_9ABC};
    vecs[7]  = '{OP_LH,  32'h1000_0000, 1'b1, 32'h1234_80FF, 32'hFFFF_80FF};
    vecs[8]  = '{OP_LHU, 32'h1000_0001, 1'b1, 32'h1234_80FF, 32'h0000_80FF};
    vecs[9]  = '{OP_LW,  32'h1000_0003, 1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D};
    vecs[10] = '{5'b0,   32'h1000_0002, 1'b1, 32'hCAFE_F00D, 32'h1000_0002};
    vecs[11] = '{OP_LW,  32'h1000_0001, 1'b0, 32'hCAFE_F00D, 32'h1000_0001};

    // Reset state.
    rst = 1'b1;
    stall = '0;
    ex_to_mem_bus = make_bus(OP_LW, 32'h1, 1'b1, 5'd3);
    data_sram_rdata = 32'h5A5A_5A5A;
    tick();
    tick();
    check("reset_wb", 136'(mem_to_wb_bus), 136'd0);
    check("reset_id", 136'(mem_to_id_bus), 136'd0);
    check("reset_first", 136'(dut.first_r), 136'd0);
    rst = 1'b0;

    // Load alignment table.
    for (int i = 0; i < 12; i++) begin
      stall = '0;
      ex_to_mem_bus = make_bus(vecs[i].ld_op, vecs[i].ex_result, vecs[i].sel, 5'(i + 1));
      data_sram_rdata = 32'h0;
      tick();
      data_sram_rdata = vecs[i].rdata;
      #1;
      check($sformatf("vec%0d_wb_wdata", i), 136'(wb.rf_wdata), 136'(vecs[i].exp));
      check($sformatf("vec%0d_id_wdata", i), 136'(id.rf_wdata), 136'(vecs[i].exp));
      check($sformatf("vec%0d_we_waddr", i), 136'({wb.rf_we, wb.rf_waddr}), 136'({1'b1, 5'(i + 1)}));
    end
    check("pc_pass", 136'(wb.pc), 136'h0000_0000_0000_0000_0000_0000_BFC0_0100);

    // lw frozen for 3 cycles while the SRAM word changes.
    stall = '0;
    ex_to_mem_bus = make_bus(OP_LW, 32'h2000_0000, 1'b1, 5'd9);
    tick();
    data_sram_rdata = 32'h1111_2222;
    stall = 6'b011000;
    ex_to_mem_bus = make_bus(OP_LB, 32'h2000_0003, 1'b1, 5'd10);
    #1;
    check("stall_c0", 136'(wb.rf_wdata), 136'h1111_2222);
    for (int c = 1; c <= 3; c++) begin
      tick();
      data_sram_rdata = 32'hDEAD_BEEF;
      #1;
      check($sformatf("stall_c%0d_wdata", c), 136'(wb.rf_wdata), 136'h1111_2222);
      check($sformatf("stall_c%0d_waddr", c), 136'(wb.rf_waddr), 136'd9);
    end

    // Bubble: MEM stopped, WB running.
    stall = '0;
    b = make_bus(5'b0, 32'h0000_0444, 1'b0, 5'd4);
    b.hi_we = 1'b1; b.hi_wdata = 32'h0000_0AAA;
    b.lo_we = 1'b1; b.lo_wdata = 32'h0000_0BBB;
    ex_to_mem_bus = b;
    tick();
    check("pre_bubble_hilo", 136'({wb.hi_we, wb.lo_we, wb.rf_we}), 136'(3'b111));
    stall = 6'b001000;
    tick();
    check("bubble_wb", 136'(mem_to_wb_bus), 136'd0);
    check("bubble_id", 136'(mem_to_id_bus), 136'd0);

    // mfhi / mflo selection.
    stall = '0;
    b = make_bus(5'b0, 32'h1357_9BDF, 1'b0, 5'd8);
    b.r_hi = 1'b1; b.r_hi_data = 32'h55AA_55AA;
    ex_to_mem_bus = b;
    tick();
    check("mfhi_wb", 136'({wb.rf_we, wb.rf_waddr, wb.rf_wdata}), 136'({1'b1, 5'd8, 32'h55AA_55AA}));
    check("mfhi_id", 136'({id.rf_we, id.rf_waddr, id.rf_wdata}), 136'({1'b1, 5'd8, 32'h55AA_55AA}));
    b.r_lo = 1'b1; b.r_lo_data = 32'h0F0F_0F0F;
    ex_to_mem_bus = b;
    tick();
    check("hi_over_lo", 136'(wb.rf_wdata), 136'h55AA_55AA);
    b.r_hi = 1'b0;
    ex_to_mem_bus = b;
    tick();
    check("mflo", 136'(id.rf_wdata), 136'h0F0F_0F0F);

    // Reset during a held load, then a fresh lw.
    ex_to_mem_bus = make_bus(OP_LW, 32'h2400_0000, 1'b1, 5'd12);
    tick();
    data_sram_rdata = 32'h0BAD_F00D;
    stall = 6'b011000;
    #1;
    check("held_load", 136'(wb.rf_wdata), 136'h0BAD_F00D);
    tick();
    rst = 1'b1;
    tick();
    check("rst_mid_wb", 136'(mem_to_wb_bus), 136'd0);
    check("rst_mid_id", 136'(mem_to_id_bus), 136'd0);
    check("rst_mid_first", 136'(dut.first_r), 136'd0);
    rst = 1'b0;
    stall = '0;
    ex_to_mem_bus = make_bus(OP_LW, 32'h3000_0000, 1'b1, 5'd5);
    tick();
    data_sram_rdata = 32'h7777_8888;
    #1;
    check("post_rst_lw", 136'({wb.rf_we, wb.rf_waddr, wb.rf_wdata}), 136'({1'b1, 5'd5, 32'h7777_8888}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
